// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: column drive, row sampling, frame debounce with
// ghost rejection, one-shot key events and a 32-bit hex entry shift register.
module keypad_scan #(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  row,
    input  logic        en,
    input  logic        clr,
    output logic [3:0]  col,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic        key_held,
    output logic [31:0] data
);
    localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int DW = $clog2(DEBOUNCE_SCANS + 1);

    typedef enum logic {IDLE, PRESSED} state_t;

    state_t         state_q, state_d;
    logic [3:0]     row_s1_q, row_s1_d, row_s2_q, row_s2_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [1:0]     col_idx_q, col_idx_d;
    logic [15:0]    frame_q, frame_d;
    logic [4:0]     prev_cand_q, prev_cand_d;
    logic [DW-1:0]  db_cnt_q, db_cnt_d;
    logic [3:0]     key_code_q, key_code_d;
    logic           key_valid_q, key_valid_d;
    logic           key_held_q, key_held_d;
    logic [31:0]    data_q, data_d;

    logic           last_dwell, frame_end, stable, accept;
    logic [3:0]     sample;
    logic [15:0]    full_frame;
    logic [4:0]     ones;
    logic [3:0]     hit;
    logic [4:0]     cand;

    // Index is col*4 + row; returns the printed legend of that key.
    function automatic logic [3:0] key_map(input logic [3:0] idx);
        case (idx)
            4'd0:  key_map = 4'h1;  4'd1:  key_map = 4'h4;
            4'd2:  key_map = 4'h7;  4'd3:  key_map = 4'h0;
            4'd4:  key_map = 4'h2;  4'd5:  key_map = 4'h5;
            4'd6:  key_map = 4'h8;  4'd7:  key_map = 4'hF;
            4'd8:  key_map = 4'h3;  4'd9:  key_map = 4'h6;
            4'd10: key_map = 4'h9;  4'd11: key_map = 4'hE;
            4'd12: key_map = 4'hA;  4'd13: key_map = 4'hB;
            4'd14: key_map = 4'hC;  default: key_map = 4'hD;
        endcase
    endfunction

    always_comb begin
        state_d     = state_q;
        row_s1_d    = row;
        row_s2_d    = row_s1_q;
        cnt_d       = cnt_q + CW'(1);
        col_idx_d   = col_idx_q;
        frame_d     = frame_q;
        prev_cand_d = prev_cand_q;
        db_cnt_d    = db_cnt_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;
        data_d      = data_q;
        accept      = 1'b0;

        last_dwell = (cnt_q == CW'(SCAN_DIV - 1));
        frame_end  = last_dwell && (col_idx_q == 2'd3);
        sample     = ~row_s2_q;
        if (last_dwell) begin
            cnt_d     = '0;
            col_idx_d = col_idx_q + 2'd1;
            frame_d[col_idx_q*4 +: 4] = sample;
        end

        // Column 3's sample is combined live so the frame decodes on its last cycle.
        full_frame = {sample, frame_q[11:0]};
        ones = '0;
        hit  = '0;
        for (int i = 0; i < 16; i++) begin
            if (full_frame[i]) begin
                ones = ones + 5'd1;
                hit  = 4'(i);
            end
        end
        cand = (ones == 5'd1) ? {1'b1, key_map(hit)} : 5'd0;

        if (frame_end) begin
            prev_cand_d = cand;
            if (cand == prev_cand_q)
                db_cnt_d = (db_cnt_q == DW'(DEBOUNCE_SCANS)) ? db_cnt_q : db_cnt_q + DW'(1);
            else
                db_cnt_d = DW'(1);
        end
        stable = frame_end && (db_cnt_d == DW'(DEBOUNCE_SCANS));

        case (state_q)
            IDLE: begin
                if (stable && cand[4]) begin
                    accept      = 1'b1;
                    key_valid_d = 1'b1;
                    key_code_d  = cand[3:0];
                    key_held_d  = 1'b1;
                    state_d     = PRESSED;
                end
            end
            default: begin
                if (stable && !cand[4]) begin
                    key_held_d = 1'b0;
                    state_d    = IDLE;
                end
            end
        endcase

        if (clr)
            data_d = '0;
        else if (accept && en)
            data_d = {data_q[27:0], cand[3:0]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            row_s1_q    <= 4'hF;
            row_s2_q    <= 4'hF;
            cnt_q       <= '0;
            col_idx_q   <= '0;
            frame_q     <= '0;
            prev_cand_q <= '0;
            db_cnt_q    <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            row_s1_q    <= row_s1_d;
            row_s2_q    <= row_s2_d;
            cnt_q       <= cnt_d;
            col_idx_q   <= col_idx_d;
            frame_q     <= frame_d;
            prev_cand_q <= prev_cand_d;
            db_cnt_q    <= db_cnt_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
            data_q      <= data_d;
        end
    end

    assign col       = ~(4'b0001 << col_idx_q);
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;
    assign data      = data_q;
endmodule

// File: doc/keypad_scan.md
Name: keypad_scan

Overview:
- Input-direction counterpart to the board's multiplexed 7-segment scan path.
- Drives the columns of a 4x4 Pmod matrix keypad one at a time, samples the rows, debounces the result over whole scan frames and rejects multi-key ghosts.
- Emits one hex key code per press and shifts each code into a 32-bit entry register.
- The entry register feeds a display data input in place of button-driven entry.

Parameters:
- SCAN_DIV, 100000, clock cycles each column is driven (1 ms at 100 MHz); minimum 2.
- DEBOUNCE_SCANS, 4, consecutive identical frames required before a key state is accepted; minimum 1.

Ports:
- clk  input  1  system clock (100 MHz)
- rst  input  1  asynchronous, active-high reset
- row  input  4  keypad rows, active-low (external pull-ups), asynchronous to clk
- en  input  1  when 1, accepted presses shift into data
- clr  input  1  synchronous clear of data
- col  output  4  column drive, active-low one-hot
- key_code  output  4  hex code of the last accepted key
- key_valid  output  1  one-cycle pulse per accepted press
- key_held  output  1  1 while an accepted key remains pressed
- data  output  32  entry shift register, newest digit in [3:0]

Behaviour:
- Reset values: col=4'b1110, key_code=0, key_valid=0, key_held=0, data=0. Dwell counter, column index, frame snapshot and debounce counter are all 0. State is IDLE.
- Row synchroniser: row passes through a 2-flop synchroniser before any use.
- Scan:
  - Column index c (0..3) drives col = ~(1<<c) for SCAN_DIV cycles, then advances; wraps 3->0.
  - Synchronised rows are sampled on the last dwell cycle of each column, so lines have settled.
  - Four samples form one frame. A frame ends when column 3's sample is taken.
- Key map (row r, column c):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: 0 F E D
- Frame decode:
  - Exactly one active (low) bit -> candidate = that key.
  - Zero or two or more active bits -> candidate = NONE. Multi-key is treated as release.
- Debounce:
  - If a frame's candidate equals the previous frame's candidate, the counter increments, saturating at DEBOUNCE_SCANS. Otherwise the counter resets to 1.
  - The candidate becomes stable when the counter reaches DEBOUNCE_SCANS.
- FSM IDLE:
  - On stable key k: next cycle key_code=k, key_valid=1 for exactly one cycle, key_held=1, go to PRESSED.
  - In the same cycle, if en=1, data <= {data[27:0], k}.
- FSM PRESSED:
  - Stable NONE -> key_held=0, go to IDLE.
  - Stable different key k2 -> no pulse, stay PRESSED until stable NONE. A release is required between presses.
  - Holding a key never repeats.
- Latency: press to key_valid is at most (DEBOUNCE_SCANS+1)*4*SCAN_DIV + 4 cycles.
- Shift and clear:
  - Beyond 8 digits the oldest nibble (data[31:28]) is discarded.
  - clr=1 forces data=0 that cycle. If it coincides with an accepted press, clr wins and the digit is dropped; key_valid and key_code still update.
- key_code holds its value after release.
- Reset mid-operation (async): all state returns to reset values immediately. A key still held after reset is re-detected after a full debounce and produces a new pulse.

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=2, frame=16 cycles):
1. After reset, hold row1 low only while col=1101 for 4 frames -> exactly one key_valid pulse, key_code=5, key_held=1, data=0x00000005. Release for 3 frames -> key_held=0, no further pulse.
2. Press and release 1,2,3,A in sequence (en=1), each held 3 frames with 3 release frames -> four pulses, data=0x0000123A. col is seen cycling 1110,1101,1011,0111 every 4 cycles.
3. Bounce: key 7 pressed on alternating frames for 8 frames -> key_valid never asserts, data unchanged.
4. Ghost: keys 1 and 6 pressed together for 4 frames -> no pulse. Release 6 while keeping 1 -> one pulse, code=1.
5. Enter 9 digits 1..9 -> data=0x23456789. Then assert clr in the cycle key_valid fires for key F -> data=0, key_code=F. With en=0, press C -> pulse, data unchanged.
6. Assert rst mid-press while in PRESSED, key still held -> outputs cleared at once. Re-detect after 2+ frames produces exactly one new pulse.
